// File: rtl/score_bcd_pkg.sv
// Shared types and constants for the score BCD converter.
// Holds the FSM state encoding, the binary width and the saturation limit helper.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int BIN_W      = 32;
    localparam int DIGITS_DEF = 8;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic logic [BIN_W-1:0] max_bcd_val(input int digits);
        logic [BIN_W-1:0] value;
        value = 1;
        for (int i = 0; i < digits; i++) begin
            value = value * 10;
        end
        return value - 1;
    endfunction

endpackage

// File: rtl/score_bcd_if.sv
// Bus between the distance source / score consumers and the BCD converter.
// The master drives the conversion request; the slave (converter) returns results.
interface score_bcd_if
    import score_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
);

    logic                  start;
    logic [BIN_W-1:0]      tot_distance;
    logic [DIGITS*4-1:0]   bcd;
    logic                  done;
    logic                  busy;
    logic [BIN_W-1:0]      high_bin;
    logic                  new_high;

    modport master (
        output start,
        output tot_distance,
        input  bcd,
        input  done,
        input  busy,
        input  high_bin,
        input  new_high
    );

    modport slave (
        input  start,
        input  tot_distance,
        output bcd,
        output done,
        output busy,
        output high_bin,
        output new_high
    );

endinterface

// File: rtl/score_bcd_dabble_nibble.sv
// One BCD digit of the double-dabble adjust step: add 3 when the digit is 5 or more
// so the following left shift carries correctly into the next decimal digit.
module dabble_nibble (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/score_bcd.sv
// Samples the running distance on start, saturates it to DIGITS nines, converts it
// to packed BCD with a 32-step shift-and-add-3 engine, and tracks the session high score.
module score_bcd
    import score_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    score_bcd_if.slave  bus
);

    localparam int               BCD_W   = DIGITS * 4;
    localparam int               SCR_W   = BCD_W + BIN_W;
    localparam logic [BIN_W-1:0] MAX_VAL = max_bcd_val(DIGITS);

    state_t             state;
    state_t             next_state;
    logic [4:0]         count;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   adjusted;
    logic [BIN_W-1:0]   sat;
    logic [BIN_W-1:0]   sat_q;
    logic [BIN_W-1:0]   high_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               done_q;
    logic               busy_q;
    logic               new_high_q;
    logic               load;
    logic               shift;
    logic               finish;

    assign sat = (bus.tot_distance > MAX_VAL) ? MAX_VAL : bus.tot_distance;

    // Only the BCD field is adjusted; the binary field just shifts through.
    assign adjusted[BIN_W-1:0] = scratch[BIN_W-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_nibble
        dabble_nibble u_nibble (
            .digit    (scratch [BIN_W + 4*i +: 4]),
            .adjusted (adjusted[BIN_W + 4*i +: 4])
        );
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (count == 5'd31) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // busy tracks the registered next state so it rises at the latch edge and falls with done.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            count      <= '0;
            scratch    <= '0;
            sat_q      <= '0;
            high_q     <= '0;
            bcd_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            new_high_q <= 1'b0;
        end else begin
            state      <= next_state;
            busy_q     <= (next_state != IDLE);
            done_q     <= 1'b0;
            new_high_q <= 1'b0;
            if (load) begin
                sat_q   <= sat;
                scratch <= {{BCD_W{1'b0}}, sat};
                count   <= '0;
            end
            if (shift) begin
                scratch <= {adjusted[SCR_W-2:0], 1'b0};
                count   <= count + 5'd1;
            end
            if (finish) begin
                bcd_q  <= scratch[SCR_W-1 -: BCD_W];
                done_q <= 1'b1;
                if (sat_q > high_q) begin
                    high_q     <= sat_q;
                    new_high_q <= 1'b1;
                end
            end
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.high_bin = high_q;
    assign bus.new_high = new_high_q;

endmodule

// File: tb/tb_score_bcd.sv
// Directed bench for score_bcd: conversion results, latency, saturation, high score,
// start filtering while busy, and asynchronous reset abort.
module tb_score_bcd;

    logic Clk = 1'b0;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   busy_n;
    int   done_n;

    score_bcd_if #(.DIGITS(8)) bus ();

    score_bcd #(.DIGITS(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle start; the edge consumed here is E0.
    task automatic apply_stimulus(input logic [31:0] value);
        bus.tot_distance = value;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
    endtask

    // Ticks until done (bounded), returning edges since E0 and cycles busy was seen high.
    task automatic wait_done(output int latency, output int busy_cycles);
        latency     = 0;
        busy_cycles = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && latency < 40) begin
            tick();
            latency++;
            if (bus.busy === 1'b1) busy_cycles++;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] exp_bcd,
                                input logic exp_new, input logic [31:0] exp_high);
        check_output({tag, "_latency"}, 32'(lat), 32'd33);
        check_output({tag, "_bcd"}, bus.bcd, exp_bcd);
        check_output({tag, "_new_high"}, {31'd0, bus.new_high}, {31'd0, exp_new});
        check_output({tag, "_high_bin"}, bus.high_bin, exp_high);
        check_output({tag, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
        tick();
        check_output({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        check_output({tag, "_new_high_pulse"}, {31'd0, bus.new_high}, 32'd0);
    endtask

    initial begin
        Reset_n          = 1'b0;
        bus.start        = 1'b0;
        bus.tot_distance = '0;
        repeat (3) tick();
        check_output("rst_bcd", bus.bcd, 32'd0);
        check_output("rst_done", {31'd0, bus.done}, 32'd0);
        check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("rst_high", bus.high_bin, 32'd0);
        check_output("rst_new_high", {31'd0, bus.new_high}, 32'd0);
        Reset_n = 1'b1;
        tick();

        $display("[TB] zero conversion");
        apply_stimulus(32'd0);
        wait_done(lat, busy_n);
        check_output("zero_done", {31'd0, bus.done}, 32'd1);
        check_result("zero", 32'h0000_0000, 1'b0, 32'd0);

        $display("[TB] 12345678 conversion");
        apply_stimulus(32'd12345678);
        wait_done(lat, busy_n);
        check_output("t2_busy_cycles", 32'(busy_n), 32'd33);
        check_result("t2", 32'h1234_5678, 1'b1, 32'd12345678);

        $display("[TB] lower value keeps high score");
        apply_stimulus(32'd500);
        wait_done(lat, busy_n);
        check_result("t6", 32'h0000_0500, 1'b0, 32'd12345678);

        $display("[TB] saturation");
        apply_stimulus(32'd100000000);
        wait_done(lat, busy_n);
        check_result("t3a", 32'h9999_9999, 1'b1, 32'd99999999);
        apply_stimulus(32'hFFFF_FFFF);
        wait_done(lat, busy_n);
        check_result("t3b", 32'h9999_9999, 1'b0, 32'd99999999);

        $display("[TB] start filtering while busy");
        apply_stimulus(32'd500);
        lat    = 0;
        done_n = 0;
        repeat (9) begin
            tick();
            lat++;
        end
        bus.tot_distance = 32'd777;
        bus.start        = 1'b1;
        tick();
        lat++;
        bus.start = 1'b0;
        check_output("t4_busy_mid", {31'd0, bus.busy}, 32'd1);
        while (lat < 32) begin
            tick();
            lat++;
            if (bus.done === 1'b1) done_n++;
        end
        check_output("t4_no_early_done", 32'(done_n), 32'd0);
        bus.start = 1'b1;
        tick();
        check_output("t4_done_e33", {31'd0, bus.done}, 32'd1);
        check_output("t4_bcd", bus.bcd, 32'h0000_0500);
        check_output("t4_busy_e33", {31'd0, bus.busy}, 32'd0);
        tick();
        bus.start = 1'b0;
        check_output("t4_accept_e34", {31'd0, bus.busy}, 32'd1);
        check_output("t4_done_e34", {31'd0, bus.done}, 32'd0);
        wait_done(lat, busy_n);
        check_result("t4b", 32'h0000_0777, 1'b0, 32'd99999999);

        $display("[TB] reset mid-conversion");
        apply_stimulus(32'd999);
        repeat (15) tick();
        Reset_n = 1'b0;
        #1;
        check_output("t5_rst_bcd", bus.bcd, 32'd0);
        check_output("t5_rst_done", {31'd0, bus.done}, 32'd0);
        check_output("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("t5_rst_high", bus.high_bin, 32'd0);
        check_output("t5_rst_new_high", {31'd0, bus.new_high}, 32'd0);
        repeat (2) tick();
        Reset_n = 1'b1;
        done_n  = 0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1) done_n++;
        end
        check_output("t5_no_done", 32'(done_n), 32'd0);
        apply_stimulus(32'd42);
        wait_done(lat, busy_n);
        check_result("t5b", 32'h0000_0042, 1'b1, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
